// File: rtl/byte_unpacker.sv
// Byte unpacker: takes longwords of 1..4 valid bytes from the DMA FIFO side and
// hands them out one byte per cycle to the SCSI-side port, in a configurable byte order.
module byte_unpacker #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic [31:0] LW_IN,
   input  logic [1:0]  LW_NB,
   input  logic        LW_VALID,
   output logic        LW_READY,
   output logic [7:0]  BO,
   output logic        BO_VALID,
   input  logic        BO_READY,
   output logic        BO_LAST,
   input  logic        ABORT,
   output logic        BUSY
);

   typedef enum logic {
      EMPTY   = 1'b0,
      SENDING = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] hold;
   logic [1:0]  idx;
   logic [1:0]  nb;

   logic        valid;
   logic        last;
   logic        accept;
   logic        transfer;
   logic [1:0]  byte_sel;

   assign valid    = (state == SENDING);
   assign last     = valid && (idx == nb);

   // Ready while empty, or while the final byte leaves, so longwords chain without a gap.
   assign LW_READY = (!valid || (BO_READY && last)) && !ABORT;
   assign accept   = LW_VALID && LW_READY;
   assign transfer = valid && BO_READY;

   // Output position idx maps to a physical byte lane according to the byte order.
   assign byte_sel = BIG_ENDIAN ? (2'd3 - idx) : idx;
   assign BO       = hold[{byte_sel, 3'b000} +: 8];
   assign BO_VALID = valid;
   assign BO_LAST  = last;
   assign BUSY     = valid;

   // NOTE: non-blocking assignments keep every register update based on pre-edge values.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         // NOTE: hold is cleared too so BO reads 0x00 straight out of reset.
         state <= EMPTY;
         hold  <= '0;
         idx   <= '0;
         nb    <= '0;
      end else if (ABORT) begin
         state <= EMPTY;
         idx   <= '0;
      end else if (accept) begin
         state <= SENDING;
         hold  <= LW_IN;
         nb    <= LW_NB;
         idx   <= '0;
      end else if (transfer) begin
         if (last) begin
            state <= EMPTY;
            idx   <= '0;
         end else begin
            idx <= idx + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_byte_unpacker.sv
// Self-checking bench for byte_unpacker: both byte orders side by side, compared every
// cycle against a queue-based model of the bytes still owed to the consumer.
module tb_byte_unpacker;

   logic        CLK = 1'b0;
   logic        nRESET;
   logic [31:0] LW_IN;
   logic [1:0]  LW_NB;
   logic        LW_VALID;
   logic        BO_READY;
   logic        ABORT;

   logic        rdy_be, rdy_le;
   logic [7:0]  bo_be, bo_le;
   logic        vld_be, vld_le, last_be, last_le, busy_be, busy_le;

   always #5 CLK = ~CLK;

   byte_unpacker #(.BIG_ENDIAN(1'b1)) u_be (
      .CLK(CLK), .nRESET(nRESET), .LW_IN(LW_IN), .LW_NB(LW_NB), .LW_VALID(LW_VALID),
      .LW_READY(rdy_be), .BO(bo_be), .BO_VALID(vld_be), .BO_READY(BO_READY),
      .BO_LAST(last_be), .ABORT(ABORT), .BUSY(busy_be)
   );

   byte_unpacker #(.BIG_ENDIAN(1'b0)) u_le (
      .CLK(CLK), .nRESET(nRESET), .LW_IN(LW_IN), .LW_NB(LW_NB), .LW_VALID(LW_VALID),
      .LW_READY(rdy_le), .BO(bo_le), .BO_VALID(vld_le), .BO_READY(BO_READY),
      .BO_LAST(last_le), .ABORT(ABORT), .BUSY(busy_le)
   );

   int checks = 0;
   int errors = 0;

   // Bytes still owed, in send order, and the last longword captured.
   logic [7:0]  q_be[$];
   logic [7:0]  q_le[$];
   logic [31:0] m_hold;

   // k-th byte sent of word w for the given order.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input int k, input bit be);
      int sh;
      sh = be ? 8 * (3 - k) : 8 * k;
      return 8'((w >> sh) & 32'hFF);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_ready();
      return (q_be.size() == 0 || (BO_READY && q_be.size() == 1)) && !ABORT;
   endfunction

   task automatic check_all();
      logic [7:0] e_be, e_le;
      e_be = (q_be.size() != 0) ? q_be[0] : byte_of(m_hold, 0, 1'b1);
      e_le = (q_le.size() != 0) ? q_le[0] : byte_of(m_hold, 0, 1'b0);
      check("bo_be",    bo_be,   e_be);
      check("bo_le",    bo_le,   e_le);
      check("valid_be", vld_be,  q_be.size() != 0);
      check("valid_le", vld_le,  q_le.size() != 0);
      check("last_be",  last_be, q_be.size() == 1);
      check("last_le",  last_le, q_le.size() == 1);
      check("busy_be",  busy_be, q_be.size() != 0);
      check("busy_le",  busy_le, q_le.size() != 0);
      check("ready_be", rdy_be,  exp_ready());
      check("ready_le", rdy_le,  exp_ready());
   endtask

   task automatic model_step();
      logic acc;
      if (ABORT) begin
         q_be.delete();
         q_le.delete();
      end else begin
         acc = LW_VALID && exp_ready();
         if (q_be.size() != 0 && BO_READY) begin
            void'(q_be.pop_front());
            void'(q_le.pop_front());
         end
         if (acc) begin
            m_hold = LW_IN;
            for (int k = 0; k <= int'(LW_NB); k++) begin
               q_be.push_back(byte_of(LW_IN, k, 1'b1));
               q_le.push_back(byte_of(LW_IN, k, 1'b0));
            end
         end
      end
   endtask

   task automatic model_reset();
      q_be.delete();
      q_le.delete();
      m_hold = '0;
   endtask

   // One clock: drive away from the rising edge, check pre-edge outputs, advance the model.
   task automatic cycle(input logic v, input logic [31:0] w, input logic [1:0] nb,
                        input logic br, input logic ab);
      @(negedge CLK);
      LW_VALID = v;
      LW_IN    = w;
      LW_NB    = nb;
      BO_READY = br;
      ABORT    = ab;
      #1;
      check_all();
      model_step();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_bo_be"},  bo_be,  8'h00);
      check({tag, "_bo_le"},  bo_le,  8'h00);
      check({tag, "_vld"},    vld_be | vld_le, 1'b0);
      check({tag, "_last"},   last_be | last_le, 1'b0);
      check({tag, "_busy"},   busy_be | busy_le, 1'b0);
      check({tag, "_ready"},  rdy_be & rdy_le, 1'b1);
   endtask

   logic [7:0] seq_be[4];
   logic [7:0] seq_le[4];

   initial begin
      nRESET = 1'b0; LW_VALID = 1'b0; LW_IN = '0; LW_NB = '0; BO_READY = 1'b0; ABORT = 1'b0;
      model_reset();
      #1;
      check_reset_values("reset");
      @(negedge CLK);
      nRESET = 1'b1;

      // Full word, both orders, explicit byte sequence.
      seq_be = '{8'h11, 8'h22, 8'h33, 8'h44};
      seq_le = '{8'h44, 8'h33, 8'h22, 8'h11};
      cycle(1'b1, 32'h11223344, 2'd3, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
         check("seq_be", bo_be, seq_be[k]);
         check("seq_le", bo_le, seq_le[k]);
         check("seq_last", last_be, k == 3);
      end
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

      // Back-to-back longwords with LW_VALID held.
      cycle(1'b1, 32'hAABBCCDD, 2'd3, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cycle(1'b1, 32'h01020304, 2'd3, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

      // Two-byte word with consumer stalls.
      cycle(1'b1, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      check("stall_de", bo_be, 8'hDE);
      cycle(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      check("stall_ad0", bo_be, 8'hAD);
      cycle(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      check("stall_ad1", {last_be, bo_be}, {1'b1, 8'hAD});
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      check("stall_empty", busy_be, 1'b0);

      // Abort at byte index 1, then a fresh word starts at byte 0.
      cycle(1'b1, 32'h11223344, 2'd3, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'h99999999, 2'd3, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      check("abort_empty", {vld_be, busy_be, rdy_be}, 3'b001);
      cycle(1'b1, 32'h55667788, 2'd3, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      check("abort_restart", bo_be, 8'h55);
      for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

      // Asynchronous reset mid-word, checked before the next rising edge.
      cycle(1'b1, 32'hCAFEF00D, 2'd3, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      @(negedge CLK);
      #2;
      nRESET = 1'b0;
      #1;
      check_reset_values("async_reset");
      model_reset();
      @(negedge CLK);
      nRESET = 1'b1;
      cycle(1'b1, 32'h0BADBEEF, 2'd2, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      check("post_reset", bo_be, 8'h0B);
      for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/byte_unpacker.md
BYTE_UNPACKER -- requirements
Module: byte_unpacker

Interface
REQ-001 Parameter BIG_ENDIAN, default 1, byte order: 1 = LW_IN[31:24] sent first, 0 = LW_IN[7:0] sent first.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 nRESET  input  1  reset, asynchronous assert, active-low.
REQ-004 LW_IN  input  32  longword from DMA FIFO side.
REQ-005 LW_NB  input  2  valid byte count minus 1 for LW_IN (3 = full longword, 0 = one byte).
REQ-006 LW_VALID  input  1  LW_IN/LW_NB valid.
REQ-007 LW_READY  output  1  block can accept a longword this cycle.
REQ-008 BO  output  8  byte to SCSI-side port.
REQ-009 BO_VALID  output  1  BO holds a valid byte.
REQ-010 BO_READY  input  1  consumer takes BO this cycle.
REQ-011 BO_LAST  output  1  BO is final valid byte of current longword.
REQ-012 ABORT  input  1  synchronous discard of held longword.
REQ-013 BUSY  output  1  longword held, bytes outstanding.

Function
REQ-014 Internal state SHALL be: 32-bit hold register, 2-bit byte index IDX, 2-bit end index NB, valid flag; states EMPTY (valid=0) and SENDING (valid=1).
REQ-015 Accept SHALL occur on an edge where LW_VALID=1 and LW_READY=1: hold <= LW_IN, NB <= LW_NB, IDX <= 0, valid <= 1.
REQ-016 LW_READY SHALL be combinational: (!valid | (BO_READY & BO_LAST)) & !ABORT.
REQ-017 Byte transfer SHALL occur on an edge where BO_VALID=1 and BO_READY=1.
REQ-018 On transfer with IDX != NB: IDX <= IDX+1, state stays SENDING.
REQ-019 On transfer with IDX == NB and no simultaneous accept: valid <= 0, IDX <= 0 (SENDING -> EMPTY).
REQ-020 On transfer with IDX == NB and simultaneous accept: new longword loads per REQ-015; no idle cycle between longwords.
REQ-021 BO SHALL be byte IDX of hold: BIG_ENDIAN=1 -> hold[31-8*IDX -: 8]; BIG_ENDIAN=0 -> hold[8*IDX+7 -: 8].
REQ-022 BO_VALID = valid; BO_LAST = valid & (IDX == NB); BUSY = valid.
REQ-023 BO, BO_LAST SHALL remain stable while BO_VALID=1 and BO_READY=0.
REQ-024 Latency: byte 0 SHALL be on BO with BO_VALID=1 in the cycle after the accepting edge; throughput one byte per cycle while BO_READY=1.
REQ-025 ABORT=1 SHALL take priority over accept and transfer: next edge valid <= 0, IDX <= 0, hold unchanged; no LW accepted in that cycle.
REQ-026 BO_READY SHALL be ignored while BO_VALID=0; LW_IN/LW_NB SHALL be ignored unless accept occurs.
REQ-027 With LW_NB=0 the longword SHALL produce exactly one byte with BO_LAST=1.

Reset
REQ-028 nRESET=0 SHALL immediately force valid=0, IDX=0, NB=0, hold=0, giving BO=0x00, BO_VALID=0, BO_LAST=0, BUSY=0, LW_READY=1 (ABORT low).
REQ-029 Reset asserted mid-longword SHALL discard remaining bytes; after release first accept behaves as from EMPTY.

Verification
REQ-030 BIG_ENDIAN=1, LW_IN=0x11223344, LW_NB=3, BO_READY=1 -> BO 0x11,0x22,0x33,0x44 on four consecutive cycles, BO_LAST only on 0x44.
REQ-031 BIG_ENDIAN=0, same input -> BO 0x44,0x33,0x22,0x11.
REQ-032 Back-to-back 0xAABBCCDD then 0x01020304, LW_VALID held, BO_READY=1 -> 8 bytes in 8 consecutive cycles, LW_READY high only in cycles where BO_LAST=1 (after first accept).
REQ-033 LW_NB=1 with 0xDEADBEEF (BIG_ENDIAN=1), BO_READY toggled 1,0,0,1 -> BO 0xDE then 0xAD held stable two stalled cycles, BO_LAST=1 on 0xAD, then EMPTY.
REQ-034 ABORT pulsed while IDX=1 of 0x11223344 -> next cycle BO_VALID=0, BUSY=0, LW_READY=1; next accept starts at byte 0 of new word.
REQ-035 nRESET pulsed low mid-longword -> all outputs at REQ-028 values asynchronously, before next CLK edge.
